pwm_ramp_seq: RTL and testbench
===============================

// Module: pwm_ramp_seq
// PURPOSE
//  Hardware duty-cycle sequencer in front of one pwm_ip instance. The CPU programs a start/end duty,
//  step size and hold time; the block then issues DUTY writes on the PWM bus autonomously
//  (ramp / triangle "breathing"). A CPU pass-through window shares the same PWM bus, with CPU priority.
// PARAMETERS
//  DUTY_W    16   width of start/end/step/current duty values (zero-extended to 32 on the PWM bus)
//  HOLD_W    24   width of hold counter (cycles between successive DUTY writes)
//  DUTY_ADDR 4'h8 PWM register offset targeted by sequencer writes
// PORTS
//  clk        in   1   clock
//  resetn     in   1   synchronous, active-low reset
//  s_sel      in   1   CPU select, sequencer register window
//  s_we       in   1   CPU write enable (sequencer window)
//  s_addr     in   4   sequencer register offset
//  s_wdata    in   32  CPU write data (sequencer window)
//  s_rdata    out  32  sequencer read data, combinational, 0 when !s_sel or s_we
//  p_sel      in   1   CPU select, PWM pass-through window
//  p_we       in   1   CPU write enable (PWM window)
//  p_addr     in   4   PWM register offset from CPU
//  p_wdata    in   32  CPU write data to PWM
//  p_rdata    out  32  = m_rdata when p_sel, else 0
//  m_sel      out  1   PWM bus select (to pwm_ip i_sel)
//  m_we       out  1   PWM bus write enable
//  m_addr     out  4   PWM bus offset
//  m_wdata    out  32  PWM bus write data
//  m_rdata    in   32  PWM bus read data (from pwm_ip o_rdata)
//  busy       out  1   sequence running
// BEHAVIOUR
//  Registers (s_addr): 0x0 CTRL  w: [0]START [1]TRI [2]LOOP; r: {cur_duty[15:0],12'b0,dir,LOOP,TRI,busy}
//   0x4 RANGE [15:0]start [31:16]end; 0x8 STEP [15:0]; 0xC HOLD [HOLD_W-1:0]. Reset: all 0, busy=0.
//  Master mux (combinational): p_sel -> m_* = p_*; else seq write pending -> m_sel=1,m_we=1,
//   m_addr=DUTY_ADDR, m_wdata={0,cur_duty}; else all m_* = 0. Seq write accepted only when !p_sel;
//   blocked write stays pending, value unchanged, retried every cycle (CPU always wins).
//  FSM: IDLE -> LOAD (CTRL write with START=1) -> HOLD -> WRITE -> HOLD ... -> IDLE.
//   LOAD: cur_duty=start, dir=(end>=start ? up : down), pending write; accepted -> HOLD.
//   HOLD: hold_cnt loaded with max(HOLD,1) on acceptance; decrements; at 1 -> compute next, WRITE.
//   Accepted DUTY writes spaced exactly max(HOLD,1) cycles when no CPU collision.
//   Next value: cur +/- max(STEP,1), saturated at the leg target (end when outbound, start when
//   returning); arithmetic DUTY_W+1 bits, no wrap-around.
//   Leg complete (cur==target after an accepted write): ramp (TRI=0): LOOP ? restart at start : IDLE;
//   triangle: outbound -> reverse dir, return leg; return complete -> LOOP ? new outbound : IDLE.
//  start==end: single write of start, then leg-complete rule applies (LOOP holds re-writing start).
//  CTRL write with START=0 while busy: IDLE next cycle, pending write dropped, no further m writes.
//  CTRL write with START=1 while busy: restart at LOAD with current RANGE/STEP/HOLD.
//  RANGE/STEP/HOLD writes while busy take effect at next value computation / hold reload.
//  busy=1 in all states except IDLE; CTRL[0] read back as busy. Reset mid-sequence: IDLE, m_* = 0.
//  START clears itself: busy drops to 0 at natural sequence end.
// STRUCTURE
//  Package pwm_seq_pkg: register offsets (SEQ_CTRL/RANGE/STEP/HOLD), pwm_ip offsets
//   (CTRL 0x0, PERIOD 0x4, DUTY 0x8, STATUS 0xC), FSM state encoding, CTRL bit indices.
//  One sub-module: pwm_bus_mux (CPU/sequencer priority mux + accept signal), rest flat.
// TESTING
//  start=0,end=40,step=10,hold=5,TRI=0,LOOP=0 -> DUTY writes 0,10,20,30,40 five cycles apart; busy=0 after.
//  start=0,end=25,step=10,hold=3,TRI=1 -> writes 0,10,20,25,15,5,0 then IDLE; dir flips after 25.
//  start=50,end=20,step=0,hold=0 -> down ramp 50,49..20, one write per cycle, never below 20.
//  p_sel+p_we held 3 cycles at seq write time -> CPU writes pass through, seq write delayed 3 cycles, value kept.
//  LOOP=1 ramp running, CTRL=0 mid-hold -> no m writes after next cycle, busy=0; resetn mid-write -> m_*=0.
//  Read via p window (p_addr=0x8) -> p_rdata equals m_rdata; s read 0x0 shows cur_duty, busy.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM duty-cycle ramp sequencer: register map,
// pwm_ip register offsets, CTRL bit positions and FSM state encoding.
package pwm_seq_pkg;

    localparam logic [3:0] SEQ_CTRL  = 4'h0;
    localparam logic [3:0] SEQ_RANGE = 4'h4;
    localparam logic [3:0] SEQ_STEP  = 4'h8;
    localparam logic [3:0] SEQ_HOLD  = 4'hC;

    localparam logic [3:0] PWM_CTRL   = 4'h0;
    localparam logic [3:0] PWM_PERIOD = 4'h4;
    localparam logic [3:0] PWM_DUTY   = 4'h8;
    localparam logic [3:0] PWM_STATUS = 4'hC;

    localparam int CTRL_START = 0;
    localparam int CTRL_TRI   = 1;
    localparam int CTRL_LOOP  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_WRITE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/pwm_bus_mux.sv
// PWM bus arbiter: the CPU pass-through window always wins; the sequencer's
// DUTY write only goes out (and is accepted) on cycles the CPU leaves idle.
module pwm_bus_mux #(
    parameter logic [3:0] DUTY_ADDR = 4'h8
) (
    input  logic        p_sel,
    input  logic        p_we,
    input  logic [3:0]  p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    input  logic        seq_req,
    input  logic [31:0] seq_wdata,
    output logic        seq_accept,
    output logic        m_sel,
    output logic        m_we,
    output logic [3:0]  m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    always_comb begin
        m_sel   = 1'b0;
        m_we    = 1'b0;
        m_addr  = 4'h0;
        m_wdata = 32'h0;
        if (p_sel) begin
            m_sel   = 1'b1;
            m_we    = p_we;
            m_addr  = p_addr;
            m_wdata = p_wdata;
        end else if (seq_req) begin
            m_sel   = 1'b1;
            m_we    = 1'b1;
            m_addr  = DUTY_ADDR;
            m_wdata = seq_wdata;
        end
    end

    assign seq_accept = seq_req && !p_sel;
    assign p_rdata    = p_sel ? m_rdata : 32'h0;

endmodule

// File: rtl/pwm_ramp_seq.sv
// Autonomous duty-cycle sequencer (ramp / triangle breathing) driving DUTY
// writes into a pwm_ip, sharing the PWM bus with a CPU pass-through window.
module pwm_ramp_seq
    import pwm_seq_pkg::*;
#(
    parameter int unsigned DUTY_W    = 16,
    parameter int unsigned HOLD_W    = 24,
    parameter logic [3:0]  DUTY_ADDR = PWM_DUTY
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s_sel,
    input  logic        s_we,
    input  logic [3:0]  s_addr,
    input  logic [31:0] s_wdata,
    output logic [31:0] s_rdata,
    input  logic        p_sel,
    input  logic        p_we,
    input  logic [3:0]  p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        m_sel,
    output logic        m_we,
    output logic [3:0]  m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    seq_state_e        state_q, state_d;
    logic [DUTY_W-1:0] cur_q, cur_d, start_q, start_d, end_q, end_d, step_q, step_d;
    logic [HOLD_W-1:0] hold_q, hold_d, cnt_q, cnt_d;
    logic              dir_q, dir_d, ret_q, ret_d, tri_q, tri_d, loop_q, loop_d;

    logic              seq_req, seq_accept, s_wr, ctrl_wr;
    logic              leg_done, finish, nxt_dir, nxt_ret;
    logic [DUTY_W-1:0] eff_step, target, nxt_cur;
    logic [HOLD_W-1:0] eff_hold;

    // Step toward target without overshooting; DUTY_W+1 bits catch carry/borrow.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] step,
        input logic [DUTY_W-1:0] tgt,
        input logic              down
    );
        logic [DUTY_W:0] sum;
        logic [DUTY_W-1:0] res;
        if (!down) begin
            sum = {1'b0, cur} + {1'b0, step};
            res = (sum >= {1'b0, tgt}) ? tgt : sum[DUTY_W-1:0];
        end else begin
            sum = {1'b0, cur} - {1'b0, step};
            res = (sum[DUTY_W] || (sum[DUTY_W-1:0] <= tgt)) ? tgt : sum[DUTY_W-1:0];
        end
        return res;
    endfunction

    pwm_bus_mux #(.DUTY_ADDR(DUTY_ADDR)) u_mux (
        .p_sel      (p_sel),
        .p_we       (p_we),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_rdata    (p_rdata),
        .seq_req    (seq_req),
        .seq_wdata  (32'(cur_q)),
        .seq_accept (seq_accept),
        .m_sel      (m_sel),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            start_q <= '0;
            end_q   <= '0;
            step_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            ret_q   <= 1'b0;
            tri_q   <= 1'b0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            start_q <= start_d;
            end_q   <= end_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            ret_q   <= ret_d;
            tri_q   <= tri_d;
            loop_q  <= loop_d;
        end
    end

    // dir: 1 = counting down; ret: on the return leg of a triangle.
    always_comb begin
        eff_step = (step_q == '0) ? DUTY_W'(1) : step_q;
        eff_hold = (hold_q == '0) ? HOLD_W'(1) : hold_q;
        target   = ret_q ? start_q : end_q;
        leg_done = (cur_q == target);
        finish   = leg_done && !loop_q && (!tri_q || ret_q);
        nxt_dir  = dir_q;
        nxt_ret  = ret_q;
        nxt_cur  = step_toward(cur_q, eff_step, target, dir_q);
        if (leg_done) begin
            if (!tri_q) begin
                nxt_ret = 1'b0;
                nxt_dir = (end_q < start_q);
                nxt_cur = start_q;
            end else if (!ret_q) begin
                nxt_ret = 1'b1;
                nxt_dir = !dir_q;
                nxt_cur = step_toward(cur_q, eff_step, start_q, !dir_q);
            end else begin
                nxt_ret = 1'b0;
                nxt_dir = (end_q < start_q);
                nxt_cur = step_toward(cur_q, eff_step, end_q, (end_q < start_q));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        start_d = start_q;
        end_d   = end_q;
        step_d  = step_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        ret_d   = ret_q;
        tri_d   = tri_q;
        loop_d  = loop_q;
        s_wr    = s_sel && s_we;
        ctrl_wr = s_wr && (s_addr == SEQ_CTRL);

        if (s_wr) begin
            case (s_addr)
                SEQ_RANGE: begin
                    start_d = s_wdata[DUTY_W-1:0];
                    end_d   = s_wdata[16 +: DUTY_W];
                end
                SEQ_STEP:  step_d = s_wdata[DUTY_W-1:0];
                SEQ_HOLD:  hold_d = s_wdata[HOLD_W-1:0];
                default: ;
            endcase
        end

        case (state_q)
            ST_LOAD, ST_WRITE: begin
                if (seq_accept) begin
                    if (finish) begin
                        state_d = ST_IDLE;
                    end else if (eff_hold == HOLD_W'(1)) begin
                        cur_d   = nxt_cur;
                        dir_d   = nxt_dir;
                        ret_d   = nxt_ret;
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d   = eff_hold;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // The write cycle itself is the last of the hold interval.
                if (cnt_q <= HOLD_W'(2)) begin
                    cur_d   = nxt_cur;
                    dir_d   = nxt_dir;
                    ret_d   = nxt_ret;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            default: ;
        endcase

        if (ctrl_wr) begin
            tri_d  = s_wdata[CTRL_TRI];
            loop_d = s_wdata[CTRL_LOOP];
            if (s_wdata[CTRL_START]) begin
                state_d = ST_LOAD;
                cur_d   = start_q;
                dir_d   = (end_q < start_q);
                ret_d   = 1'b0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        seq_req = (state_q == ST_LOAD) || (state_q == ST_WRITE);
        busy    = (state_q != ST_IDLE);
        s_rdata = 32'h0;
        if (s_sel && !s_we) begin
            case (s_addr)
                SEQ_CTRL:  s_rdata = {16'(cur_q), 12'h0, dir_q, loop_q, tri_q, busy};
                SEQ_RANGE: s_rdata = {16'(end_q), 16'(start_q)};
                SEQ_STEP:  s_rdata = 32'(step_q);
                SEQ_HOLD:  s_rdata = 32'(hold_q);
                default:   s_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_ramp_seq.sv
// Self-checking bench: programs ramp/triangle sequences (directed and random)
// and compares observed PWM-bus DUTY writes against an arithmetic model.
module tb_pwm_ramp_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_sel, s_we;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata, s_rdata;
    logic        p_sel, p_we;
    logic [3:0]  p_addr;
    logic [31:0] p_wdata, p_rdata;
    logic        m_sel, m_we;
    logic [3:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        busy;

    always #5 clk = ~clk;

    pwm_ramp_seq dut (
        .clk     (clk),
        .resetn  (resetn),
        .s_sel   (s_sel),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .p_sel   (p_sel),
        .p_we    (p_we),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_rdata (p_rdata),
        .m_sel   (m_sel),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .busy    (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Bus monitor: every sequencer DUTY write seen on the PWM bus.
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [31:0] wr_val[$];
    logic [31:0] wr_rd[$];
    int          wr_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (mon_en && m_sel && m_we && (m_addr == 4'h8) && !p_sel) begin
            wr_val.push_back(m_wdata);
            wr_rd.push_back(s_rdata);
            wr_cyc.push_back(cyc);
        end
    end

    // Reference model: list of duty values and direction flag (1 = down).
    int exp_v[$];
    bit exp_d[$];

    task automatic model(input int st, input int en, input int sp, input bit tr);
        int s;
        int v;
        bit od;
        s  = (sp == 0) ? 1 : sp;
        v  = st;
        od = (en < st);
        exp_v.delete();
        exp_d.delete();
        exp_v.push_back(v);
        exp_d.push_back(od);
        while (v != en) begin
            if (od) v = (v - s < en) ? en : v - s;
            else    v = (v + s > en) ? en : v + s;
            exp_v.push_back(v);
            exp_d.push_back(od);
        end
        if (tr) begin
            while (v != st) begin
                if (od) v = (v + s > st) ? st : v + s;
                else    v = (v - s < st) ? st : v - s;
                exp_v.push_back(v);
                exp_d.push_back(!od);
            end
        end
    endtask

    task automatic clear_mon();
        wr_val.delete();
        wr_rd.delete();
        wr_cyc.delete();
    endtask

    task automatic s_write(input logic [3:0] a, input logic [31:0] d);
        s_sel   = 1'b1;
        s_we    = 1'b1;
        s_addr  = a;
        s_wdata = d;
        @(negedge clk);
        check_eq("s_rdata_during_write", s_rdata, 32'h0);
        @(posedge clk);
        #1;
        s_sel = 1'b0;
        s_we  = 1'b0;
    endtask

    task automatic s_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
        s_sel  = 1'b1;
        s_we   = 1'b0;
        s_addr = a;
        @(negedge clk);
        check_eq(tag, s_rdata, exp);
        @(posedge clk);
        #1;
        s_sel = 1'b0;
    endtask

    task automatic compare_run(input string tag, input int hd, input bit tr, input bit lp,
                               input int gap_idx, input int gap_extra);
        int he;
        int n;
        logic [15:0] ev;
        he = (hd == 0) ? 1 : hd;
        check_eq({tag, "_count"}, 32'(wr_val.size()), 32'(exp_v.size()));
        n = (wr_val.size() < exp_v.size()) ? wr_val.size() : exp_v.size();
        for (int i = 0; i < n; i++) begin
            ev = 16'(exp_v[i]);
            check_eq({tag, "_duty"}, wr_val[i], {16'h0, ev});
            check_eq({tag, "_ctrl_read"}, wr_rd[i], {ev, 12'h0, exp_d[i], lp, tr, 1'b1});
            if (i > 0)
                check_eq({tag, "_spacing"}, 32'(wr_cyc[i] - wr_cyc[i-1]),
                         32'((i == gap_idx) ? he + gap_extra : he));
        end
        $display("seq %s: writes=%0d expected=%0d", tag, wr_val.size(), exp_v.size());
    endtask

    task automatic run_seq(input string tag, input int st, input int en, input int sp,
                           input int hd, input bit tr, input bit collide);
        bit found;
        bit done;
        s_write(4'h4, {16'(en), 16'(st)});
        s_write(4'h8, 32'(sp));
        s_write(4'hC, 32'(hd));
        clear_mon();
        mon_en = 1'b1;
        s_write(4'h0, {29'h0, 1'b0, tr, 1'b1});
        s_sel  = 1'b1;
        s_we   = 1'b0;
        s_addr = 4'h0;
        if (collide) begin
            found = 1'b0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (m_sel && m_we && (m_addr == 4'h8)) begin
                    found = 1'b1;
                    break;
                end
            end
            check_eq({tag, "_first_write_seen"}, 32'(found), 32'd1);
            repeat (hd) @(posedge clk);
            #1;
            p_sel   = 1'b1;
            p_we    = 1'b1;
            p_addr  = 4'h0;
            p_wdata = 32'hCAFE_0001;
            repeat (3) begin
                @(negedge clk);
                check_eq({tag, "_cpu_ctl"}, 32'({m_sel, m_we, m_addr}), 32'({1'b1, 1'b1, 4'h0}));
                check_eq({tag, "_cpu_wdata"}, m_wdata, 32'hCAFE_0001);
            end
            @(posedge clk);
            #1;
            p_sel = 1'b0;
            p_we  = 1'b0;
        end
        done = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check_eq({tag, "_finished"}, 32'(done), 32'd1);
        mon_en = 1'b0;
        s_sel  = 1'b0;
        model(st, en, sp, tr);
        compare_run(tag, hd, tr, 1'b0, collide ? 1 : -1, collide ? 3 : 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   cnt;
        bit   found;
        logic [31:0] rd_val;
        int   st, en, sp, hd;
        bit   tr;

        resetn  = 1'b0;
        s_sel   = 1'b0;
        s_we    = 1'b0;
        s_addr  = 4'h0;
        s_wdata = 32'h0;
        p_sel   = 1'b0;
        p_we    = 1'b0;
        p_addr  = 4'h0;
        p_wdata = 32'h0;
        m_rdata = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        s_sel  = 1'b1;
        s_addr = 4'h0;
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_m_ctl", 32'({m_sel, m_we, m_addr}), 32'h0);
        check_eq("reset_m_wdata", m_wdata, 32'h0);
        check_eq("reset_ctrl_read", s_rdata, 32'h0);
        @(posedge clk);
        #1;
        s_sel  = 1'b0;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // CPU read through the PWM window
        rd_val  = $urandom;
        m_rdata = rd_val;
        p_sel   = 1'b1;
        p_we    = 1'b0;
        p_addr  = 4'h8;
        @(negedge clk);
        check_eq("p_read_data", p_rdata, rd_val);
        check_eq("p_read_bus", 32'({m_sel, m_we, m_addr}), 32'({1'b1, 1'b0, 4'h8}));
        @(posedge clk);
        #1;
        p_sel = 1'b0;
        @(negedge clk);
        check_eq("p_read_idle", p_rdata, 32'h0);
        check_eq("bus_idle", 32'(m_sel), 32'd0);
        @(posedge clk);
        #1;

        run_seq("ramp_up",    0, 40, 10, 5, 1'b0, 1'b0);
        run_seq("triangle",   0, 25, 10, 3, 1'b1, 1'b0);
        run_seq("ramp_down", 50, 20,  0, 0, 1'b0, 1'b0);
        run_seq("collision",  0, 40, 10, 5, 1'b0, 1'b1);

        // Looping ramp stopped in the middle of a hold interval
        s_write(4'h4, {16'd20, 16'd0});
        s_write(4'h8, 32'd10);
        s_write(4'hC, 32'd4);
        clear_mon();
        mon_en = 1'b1;
        s_write(4'h0, 32'h5);
        cnt = 0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (m_sel && m_we && (m_addr == 4'h8) && !p_sel) cnt++;
            if (cnt == 6) break;
        end
        check_eq("loop_writes_seen", 32'(cnt), 32'd6);
        @(posedge clk);
        #1;
        s_write(4'h0, 32'h0);
        cnt = (wr_val.size() < 6) ? wr_val.size() : 6;
        for (int i = 0; i < cnt; i++)
            check_eq("loop_duty", wr_val[i], 32'((i % 3) * 10));
        clear_mon();
        @(negedge clk);
        check_eq("stop_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check_eq("stop_no_writes", 32'(wr_val.size()), 32'd0);
        mon_en = 1'b0;
        $display("seq loop_stop: stopped after %0d writes", cnt);
        @(posedge clk);
        #1;

        // Register readback, then reset asserted while a write is on the bus
        s_write(4'h4, {16'd40, 16'd0});
        s_write(4'h8, 32'd10);
        s_write(4'hC, 32'd3);
        s_read("range_read", 4'h4, {16'd40, 16'd0});
        s_read("step_read", 4'h8, 32'd10);
        s_read("hold_read", 4'hC, 32'd3);
        s_write(4'h0, 32'h1);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m_sel && m_we && (m_addr == 4'h8)) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("rst_write_seen", 32'(found), 32'd1);
        resetn = 1'b0;
        @(negedge clk);
        check_eq("rst_m_ctl", 32'({m_sel, m_we, m_addr}), 32'h0);
        check_eq("rst_m_wdata", m_wdata, 32'h0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        s_sel  = 1'b1;
        s_we   = 1'b0;
        s_addr = 4'h4;
        #1;
        check_eq("rst_range_cleared", s_rdata, 32'h0);
        @(posedge clk);
        #1;
        s_sel  = 1'b0;
        resetn = 1'b1;
        $display("seq reset_mid_write: done");
        @(posedge clk);
        #1;

        for (int r = 0; r < 6; r++) begin
            st = int'($urandom_range(0, 300));
            en = int'($urandom_range(0, 300));
            sp = int'($urandom_range(0, 40));
            hd = int'($urandom_range(0, 5));
            tr = 1'($urandom_range(0, 1));
            if (tr && (en == st)) en = st + 1;
            run_seq($sformatf("rnd%0d_s%0d_e%0d_st%0d_h%0d_t%0d", r, st, en, sp, hd, tr),
                    st, en, sp, hd, tr, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
